// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-word bit positions, access sizes,
// memory-stage FSM states and the interrupt-control address-error bit.
package mips_pkg;

    localparam int CW_LOAD    = 29;
    localparam int CW_STORE   = 28;
    localparam int CW_SIZE_HI = 27;
    localparam int CW_SIZE_LO = 26;
    localparam int CW_SEXT    = 25;
    localparam int INT_ADE    = 3;

    typedef enum logic [1:0] {
        SZ_B  = 2'b00,
        SZ_H  = 2'b01,
        SZ_W  = 2'b10,
        SZ_W3 = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Lane extraction and extension of load data, plus the matching byte-enable
// mask, which the store path uses for its lanes.
module mem_load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        sext,
    output logic [31:0] result,
    output logic [3:0]  be
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;
        be       = 4'b1111;
        case (size)
            SZ_B: begin
                result = {{24{sext & byte_sel[7]}}, byte_sel};
                be     = 4'b0001 << lane;
            end
            SZ_H: begin
                result = {{16{sext & half_sel[15]}}, half_sel};
                be     = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: req/ack data-memory access with stall, load alignment
// and falling-edge MEM/WB registers. Optional macro: MEM_ADDR_EXC_EN.
module mem_stage
    import mips_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] ALURES,
    input  logic [DW-1:0] MEMDATA,
    input  logic [31:0]   CONTROLW_EXE,
    input  logic [7:0]    INTCONTROLW_EXE,
    input  logic [31:0]   MEMPC,
    input  logic [DW-1:0] MEMHILO,
    input  logic [6:0]    EXEDES,
    input  logic [1:0]    EXEWRITEHILO,
    output logic [AW-1:0] DMEM_ADDR,
    output logic          DMEM_REQ,
    output logic          DMEM_WE,
    output logic [3:0]    DMEM_BE,
    output logic [31:0]   DMEM_WDATA,
    input  logic [31:0]   DMEM_RDATA,
    input  logic          DMEM_ACK,
    output logic          MEMSTALL,
    output logic [6:0]    MEMDES,
    output logic [DW-1:0] MEMRESULT,
    output logic [6:0]    WBDES,
    output logic [1:0]    WBWRITEHILO,
    output logic [DW-1:0] WBRES,
    output logic [DW-1:0] WBHILO,
    output logic [31:0]   WBPC,
    output logic [31:0]   CONTROLW_MEM,
    output logic [7:0]    INTCONTROLW_MEM
);

    logic        ld, st, sx, is_load, fault, acc, stall;
    size_e       sz;
    logic [1:0]  lane;
    logic [31:0] load_res;
    logic [3:0]  lane_be;

    mem_state_e  state_q, state_d;
    logic [6:0]  wbdes_q, wbdes_d;
    logic [1:0]  wbhilo_en_q, wbhilo_en_d;
    logic [31:0] wbres_q, wbres_d, wbhilo_q, wbhilo_d, wbpc_q, wbpc_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [7:0]  intc_q, intc_d;

    assign ld      = CONTROLW_EXE[CW_LOAD];
    assign st      = CONTROLW_EXE[CW_STORE];
    assign sx      = CONTROLW_EXE[CW_SEXT];
    assign sz      = size_e'(CONTROLW_EXE[CW_SIZE_HI:CW_SIZE_LO]);
    assign lane    = ALURES[1:0];
    assign is_load = ld & ~st;

`ifdef MEM_ADDR_EXC_EN
    assign fault = (ld | st) & (((sz == SZ_H) & lane[0]) | (sz[1] & (lane != 2'b00)));
`else
    assign fault = 1'b0;
`endif

    assign acc   = (ld | st) & ~fault;
    assign stall = acc & ~DMEM_ACK;

    mem_load_align u_align (
        .rdata  (DMEM_RDATA),
        .lane   (lane),
        .size   (sz),
        .sext   (sx),
        .result (load_res),
        .be     (lane_be)
    );

    // Reset gates the request combinationally so it drops without waiting for a clock.
    assign DMEM_REQ  = (acc | (state_q == ST_BUSY)) & ~reset;
    assign MEMSTALL  = stall & ~reset;
    assign DMEM_ADDR = {ALURES[AW-1:2], 2'b00};
    assign DMEM_WE   = st & acc;
    assign DMEM_BE   = lane_be;
    assign MEMDES    = EXEDES;
    assign MEMRESULT = (is_load & acc & DMEM_ACK) ? load_res : ALURES;

    always_comb begin
        case (sz)
            SZ_B:    DMEM_WDATA = {4{MEMDATA[7:0]}};
            SZ_H:    DMEM_WDATA = {2{MEMDATA[15:0]}};
            default: DMEM_WDATA = MEMDATA;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (acc & ~DMEM_ACK) state_d = ST_BUSY;
            ST_BUSY: if (DMEM_ACK | ~acc) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A stalled cycle writes a bubble so the instruction retires exactly once.
        wbdes_d     = (stall | fault) ? 7'd0 : EXEDES;
        wbhilo_en_d = stall ? 2'b00 : EXEWRITEHILO;
        ctrl_d      = stall ? 32'd0 : CONTROLW_EXE;
        wbres_d     = (is_load & acc) ? load_res : ALURES;
        wbhilo_d    = MEMHILO;
        wbpc_d      = MEMPC;
        intc_d      = INTCONTROLW_EXE;
        if (fault) intc_d[INT_ADE] = 1'b1;
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wbdes_q     <= '0;
            wbhilo_en_q <= '0;
            wbres_q     <= '0;
            wbhilo_q    <= '0;
            wbpc_q      <= '0;
            ctrl_q      <= '0;
            intc_q      <= '0;
        end else begin
            state_q     <= state_d;
            wbdes_q     <= wbdes_d;
            wbhilo_en_q <= wbhilo_en_d;
            wbres_q     <= wbres_d;
            wbhilo_q    <= wbhilo_d;
            wbpc_q      <= wbpc_d;
            ctrl_q      <= ctrl_d;
            intc_q      <= intc_d;
        end
    end

    assign WBDES           = wbdes_q;
    assign WBWRITEHILO     = wbhilo_en_q;
    assign WBRES           = wbres_q;
    assign WBHILO          = wbhilo_q;
    assign WBPC            = wbpc_q;
    assign CONTROLW_MEM    = ctrl_q;
    assign INTCONTROLW_MEM = intc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage against a word-array memory model.
// Honours MEM_ADDR_EXC_EN when it is defined for the build.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALURES, MEMDATA, CONTROLW_EXE, MEMPC, MEMHILO;
    logic [7:0]  INTCONTROLW_EXE;
    logic [6:0]  EXEDES;
    logic [1:0]  EXEWRITEHILO;
    logic [31:0] DMEM_ADDR;
    logic        DMEM_REQ, DMEM_WE;
    logic [3:0]  DMEM_BE;
    logic [31:0] DMEM_WDATA, DMEM_RDATA;
    logic        DMEM_ACK;
    logic        MEMSTALL;
    logic [6:0]  MEMDES, WBDES;
    logic [31:0] MEMRESULT, WBRES, WBHILO, WBPC, CONTROLW_MEM;
    logic [1:0]  WBWRITEHILO;
    logic [7:0]  INTCONTROLW_MEM;

    int errors = 0;
    int checks = 0;
    logic [31:0] ref_mem [0:255];

    always #5 clk = ~clk;

    mem_stage #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .ALURES(ALURES), .MEMDATA(MEMDATA),
        .CONTROLW_EXE(CONTROLW_EXE), .INTCONTROLW_EXE(INTCONTROLW_EXE),
        .MEMPC(MEMPC), .MEMHILO(MEMHILO), .EXEDES(EXEDES), .EXEWRITEHILO(EXEWRITEHILO),
        .DMEM_ADDR(DMEM_ADDR), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_BE(DMEM_BE),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
        .MEMSTALL(MEMSTALL), .MEMDES(MEMDES), .MEMRESULT(MEMRESULT), .WBDES(WBDES),
        .WBWRITEHILO(WBWRITEHILO), .WBRES(WBRES), .WBHILO(WBHILO), .WBPC(WBPC),
        .CONTROLW_MEM(CONTROLW_MEM), .INTCONTROLW_MEM(INTCONTROLW_MEM)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input int sz, input logic sx);
        logic [31:0] v;
        if (sz == 0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (sx && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = (w >> ((a & 2) * 8)) & 32'hFFFF;
            if (sx && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic run_op(input logic ld, input logic st, input int sz, input logic sx,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [6:0] des, input int waits);
        logic        f, req_exp, is_ld;
        logic [31:0] ctrl, pc, hilo, res_exp, wd_exp;
        logic [7:0]  intc;
        logic [3:0]  be_exp;
        logic [1:0]  whl;
        logic [7:0]  idx;
        f = 1'b0;
`ifdef MEM_ADDR_EXC_EN
        f = (ld || st) && ((sz == 1 && addr[0]) || (sz >= 2 && addr[1:0] != 2'b00));
`endif
        req_exp = (ld || st) && !f;
        is_ld   = ld && !st;
        idx     = addr[9:2];
        ctrl = ($urandom & 32'hC1FFFFFF) | (32'(ld) << 29) | (32'(st) << 28)
             | (32'(sz) << 26) | (32'(sx) << 25);
        pc   = $urandom;
        hilo = $urandom;
        intc = 8'($urandom) & 8'hF7;
        whl  = 2'($urandom);
        res_exp = (is_ld && req_exp) ? ref_load(ref_mem[idx], addr, sz, sx) : addr;
        be_exp  = (sz == 0) ? 4'(1 << (addr % 4)) : (sz == 1) ? ((addr & 2) != 0 ? 4'd12 : 4'd3) : 4'd15;
        wd_exp  = (sz == 0) ? (data & 32'hFF) * 32'h01010101
                : (sz == 1) ? (data & 32'hFFFF) * 32'h00010001 : data;

        ALURES = addr; MEMDATA = data; CONTROLW_EXE = ctrl; MEMPC = pc; MEMHILO = hilo;
        INTCONTROLW_EXE = intc; EXEDES = des; EXEWRITEHILO = whl;
        DMEM_RDATA = ref_mem[idx];
        DMEM_ACK = (waits == 0);
        for (int c = 0; c <= waits; c++) begin
            if (c == waits) DMEM_ACK = 1'b1;
            @(posedge clk); #1;
            chk("req", 32'(DMEM_REQ), 32'(req_exp));
            chk("stall", 32'(MEMSTALL), 32'(req_exp && c < waits));
            if (req_exp) begin
                chk("addr", DMEM_ADDR, addr & 32'hFFFFFFFC);
                chk("we", 32'(DMEM_WE), 32'(st));
                if (st) begin
                    chk("be", 32'(DMEM_BE), 32'(be_exp));
                    chk("wdata", DMEM_WDATA, wd_exp);
                end
            end
            if (c == waits) begin
                chk("memdes", 32'(MEMDES), 32'(des));
                chk("memresult", MEMRESULT, res_exp);
            end
            @(negedge clk); #1;
            if (c < waits) begin
                chk("bubble_des", 32'(WBDES), 32'd0);
                chk("bubble_ctrl", CONTROLW_MEM, 32'd0);
                chk("bubble_hilo_en", 32'(WBWRITEHILO), 32'd0);
            end
        end
        chk("wbdes", 32'(WBDES), f ? 32'd0 : 32'(des));
        chk("intc", 32'(INTCONTROLW_MEM), 32'(intc) | (f ? 32'd8 : 32'd0));
        chk("ctrl_mem", CONTROLW_MEM, ctrl);
        chk("wbpc", WBPC, pc);
        chk("wbhilo", WBHILO, hilo);
        chk("wbhilo_en", 32'(WBWRITEHILO), 32'(whl));
        if (!f) chk("wbres", WBRES, res_exp);
        if (st && req_exp)
            for (int i = 0; i < 4; i++)
                if (be_exp[i]) ref_mem[idx][8*i +: 8] = wd_exp[8*i +: 8];
        DMEM_ACK = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        reset = 1'b1;
        ALURES = 0; MEMDATA = 0; CONTROLW_EXE = 0; MEMPC = 0; MEMHILO = 0;
        INTCONTROLW_EXE = 0; EXEDES = 0; EXEWRITEHILO = 0; DMEM_RDATA = 0; DMEM_ACK = 0;
        @(negedge clk); #1;
        chk("rst_wbdes", 32'(WBDES), 0);
        chk("rst_wbres", WBRES, 0);
        chk("rst_ctrl", CONTROLW_MEM, 0);
        chk("rst_intc", 32'(INTCONTROLW_MEM), 0);
        chk("rst_req", 32'(DMEM_REQ), 0);
        reset = 1'b0;
        @(negedge clk); #1;

        // ALU-only pass-through
        run_op(1'b0, 1'b0, 2, 1'b0, 32'h1234, 32'h0, 7'd5, 0);
        // LB sign-extended, zero wait
        ref_mem[8'h40] = 32'h80FFFFFF;
        run_op(1'b1, 1'b0, 0, 1'b1, 32'h103, 32'h0, 7'd9, 0);
        // SH upper half with three wait cycles
        run_op(1'b0, 1'b1, 1, 1'b0, 32'h202, 32'h0000ABCD, 7'd0, 3);
        chk("sh_mem", ref_mem[8'h80] >> 16, 32'hABCD);

        // LW, reset pulsed while waiting for the acknowledge
        ALURES = 32'h44; CONTROLW_EXE = 32'h28000000; EXEDES = 7'd3; MEMPC = 32'hCAFE0000;
        EXEWRITEHILO = 2'b11; DMEM_ACK = 1'b0;
        @(posedge clk); #1;
        chk("busy_req", 32'(DMEM_REQ), 1);
        @(negedge clk); #1;
        chk("busy_bubble", 32'(WBDES), 0);
        reset = 1'b1; #1;
        chk("rst_busy_req", 32'(DMEM_REQ), 0);
        chk("rst_busy_stall", 32'(MEMSTALL), 0);
        chk("rst_busy_pc", WBPC, 0);
        chk("rst_busy_res", WBRES, 0);
        CONTROLW_EXE = 0; #1;
        reset = 1'b0;
        @(negedge clk); #1;
        run_op(1'b1, 1'b0, 2, 1'b0, 32'h48, 32'h0, 7'd4, 0);

        // Misaligned LW: faulted with the exception macro, aligned load without it
        run_op(1'b1, 1'b0, 2, 1'b0, 32'h102, 32'h0, 7'd6, 0);
        // Back-to-back SW then LW to the same word
        run_op(1'b0, 1'b1, 2, 1'b0, 32'h10, 32'h5A5AC3C3, 7'd0, 0);
        run_op(1'b1, 1'b0, 2, 1'b0, 32'h10, 32'h0, 7'd12, 0);
        chk("sw_lw", WBRES, 32'h5A5AC3C3);
        // Load and store both set behaves as a store
        run_op(1'b1, 1'b1, 0, 1'b1, 32'h21, 32'h77, 7'd2, 1);

        for (int n = 0; n < 40; n++) begin
            logic ld, st;
            ld = 1'($urandom);
            st = 1'($urandom);
            run_op(ld, st, $urandom_range(0, 3), 1'($urandom), 32'($urandom_range(0, 1023)),
                   $urandom, 7'($urandom), (ld || st) ? $urandom_range(0, 3) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
